// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-driven ALU controller.
//   state_e : controller FSM state encoding
//   Op*     : ALU opcode constants understood by the companion ALU
package uart_alu_pkg;

  typedef enum logic [2:0] {
    StWaitA,
    StWaitB,
    StWaitOp,
    StExec,
    StSend,
    StWaitTx
  } state_e;

  localparam logic [5:0] OpAdd = 6'h20;
  localparam logic [5:0] OpSub = 6'h22;
  localparam logic [5:0] OpAnd = 6'h24;
  localparam logic [5:0] OpOr  = 6'h25;
  localparam logic [5:0] OpXor = 6'h26;
  localparam logic [5:0] OpNor = 6'h27;
  localparam logic [5:0] OpSra = 6'h03;
  localparam logic [5:0] OpSrl = 6'h02;

endpackage

// File: rtl/uart_alu_ctrl_if.sv
// Bundle of UART receive/transmit handshakes and ALU operand/result signals.
//   i_rx_data/i_rx_done : received byte and its one-cycle valid pulse
//   i_tx_done           : transmitter finished pulse
//   i_alu_result        : combinational ALU result
//   o_alu_a/b/op        : registered ALU operands and opcode
//   o_tx_data/o_tx_start: result byte and one-cycle transmit request
//   o_busy/o_drop/o_timeout : status outputs
// Modports: slave = controller side, master = environment (UART + ALU) side.
interface uart_alu_ctrl_if #(
  parameter int unsigned BUS_REG = 8,
  parameter int unsigned BUS_OP  = 6
) ();

  logic [BUS_REG-1:0] i_rx_data;
  logic               i_rx_done;
  logic               i_tx_done;
  logic [BUS_REG-1:0] i_alu_result;
  logic [BUS_REG-1:0] o_alu_a;
  logic [BUS_REG-1:0] o_alu_b;
  logic [BUS_OP-1:0]  o_alu_op;
  logic [BUS_REG-1:0] o_tx_data;
  logic               o_tx_start;
  logic               o_busy;
  logic               o_drop;
  logic               o_timeout;

  modport slave (
    input  i_rx_data, i_rx_done, i_tx_done, i_alu_result,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_drop, o_timeout
  );

  modport master (
    output i_rx_data, i_rx_done, i_tx_done, i_alu_result,
    input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_drop, o_timeout
  );

endinterface

// File: rtl/uart_alu_ctrl.sv
// UART-to-ALU frame controller. Collects operand A, operand B and an opcode byte,
// lets the external ALU compute for one cycle, then hands the result to the transmitter.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : uart_alu_ctrl_if.slave (rx/tx handshakes, ALU operands/result, status)
// Optional feature: define UART_ALU_TIMEOUT_EN to abandon a frame after TIMEOUT_CYCLES
// clocks of silence in WAIT_B/WAIT_OP; otherwise the controller waits forever and
// o_timeout is tied low.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int unsigned BUS_REG        = 8,
  parameter int unsigned BUS_OP         = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input logic             i_clk,
  input logic             i_rst_n,
  uart_alu_ctrl_if.slave  bus
);

  state_e             state_q;
  logic [BUS_REG-1:0] alu_a_q;
  logic [BUS_REG-1:0] alu_b_q;
  logic [BUS_OP-1:0]  alu_op_q;
  logic [BUS_REG-1:0] tx_data_q;
  logic               tx_start_q;
  logic               busy_q;
  logic               drop_q;

`ifdef UART_ALU_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;
  logic            timeout_q;
  logic            expired;

  assign expired = (cnt_q == CntLast);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StWaitA;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
`ifdef UART_ALU_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      drop_q     <= 1'b0;
`ifdef UART_ALU_TIMEOUT_EN
      // Counter clears unless a waiting state explicitly advances it.
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
      unique case (state_q)
        StWaitA: begin
          if (bus.i_rx_done) begin
            alu_a_q <= bus.i_rx_data;
            state_q <= StWaitB;
          end
        end
        StWaitB: begin
          // A byte in the expiry cycle wins over the timeout.
          if (bus.i_rx_done) begin
            alu_b_q <= bus.i_rx_data;
            state_q <= StWaitOp;
          end
`ifdef UART_ALU_TIMEOUT_EN
          else if (expired) begin
            state_q   <= StWaitA;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StWaitOp: begin
          if (bus.i_rx_done) begin
            alu_op_q <= bus.i_rx_data[BUS_OP-1:0];
            busy_q   <= 1'b1;
            state_q  <= StExec;
          end
`ifdef UART_ALU_TIMEOUT_EN
          else if (expired) begin
            state_q   <= StWaitA;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StExec: begin
          // tx_start is registered here so that it is high throughout SEND.
          tx_data_q  <= bus.i_alu_result;
          tx_start_q <= 1'b1;
          drop_q     <= bus.i_rx_done;
          state_q    <= StSend;
        end
        StSend: begin
          drop_q  <= bus.i_rx_done;
          state_q <= StWaitTx;
        end
        StWaitTx: begin
          drop_q <= bus.i_rx_done;
          if (bus.i_tx_done) begin
            busy_q  <= 1'b0;
            state_q <= StWaitA;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StWaitA;
        end
      endcase
    end
  end

  assign bus.o_alu_a    = alu_a_q;
  assign bus.o_alu_b    = alu_b_q;
  assign bus.o_alu_op   = alu_op_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_drop     = drop_q;
`ifdef UART_ALU_TIMEOUT_EN
  assign bus.o_timeout  = timeout_q;
`else
  assign bus.o_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl: directed frames with hand-computed results,
// drop/ignore behaviour, mid-frame reset and (with UART_ALU_TIMEOUT_EN) the timeout.
module tb_uart_alu_ctrl;
  import uart_alu_pkg::*;

  localparam int unsigned TmoCycles = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  uart_alu_ctrl_if #(.BUS_REG(8), .BUS_OP(6)) bus ();

  uart_alu_ctrl #(
    .BUS_REG       (8),
    .BUS_OP        (6),
    .TIMEOUT_CYCLES(TmoCycles)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // Reference ALU sitting beside the controller.
  function automatic logic [7:0] alu_f(logic [7:0] a, logic [7:0] b, logic [5:0] op);
    logic [7:0] r;
    case (op)
      OpAdd:   r = a + b;
      OpSub:   r = a - b;
      OpAnd:   r = a & b;
      OpOr:    r = a | b;
      OpXor:   r = a ^ b;
      OpNor:   r = ~(a | b);
      OpSra:   r = 8'($signed(a) >>> b);
      OpSrl:   r = a >> b;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign bus.i_alu_result = alu_f(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

  initial begin
    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
  end

  // Present one byte for one sampling edge; returns #1 after that edge.
  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(posedge clk); #1;
    bus.i_rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    bus.i_tx_done = 1'b1;
    @(posedge clk); #1;
    bus.i_tx_done = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_data} !== 30'h0) begin
      bad++;
      $display("FAIL reset_regs: got a=%h b=%h op=%h tx=%h want all 0",
               bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_data);
    end
    total++;
    if ({bus.o_tx_start, bus.o_busy, bus.o_drop, bus.o_timeout} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000",
               {bus.o_tx_start, bus.o_busy, bus.o_drop, bus.o_timeout});
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_add();
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    total++;
    if (bus.o_tx_start !== 1'b0 || bus.o_busy !== 1'b1) begin
      bad++;
      $display("FAIL add_exec: got start=%b busy=%b want 0/1", bus.o_tx_start, bus.o_busy);
    end
    cycle();
    total++;
    if (bus.o_tx_start !== 1'b1 || bus.o_tx_data !== 8'h08) begin
      bad++;
      $display("FAIL add_send: got start=%b data=%h want 1/08", bus.o_tx_start, bus.o_tx_data);
    end
    cycle();
    total++;
    if (bus.o_tx_start !== 1'b0 || bus.o_busy !== 1'b1 || bus.o_tx_data !== 8'h08) begin
      bad++;
      $display("FAIL add_wait_tx: got start=%b busy=%b data=%h want 0/1/08",
               bus.o_tx_start, bus.o_busy, bus.o_tx_data);
    end
    pulse_tx_done();
    total++;
    if (bus.o_busy !== 1'b0 || bus.o_alu_a !== 8'h05 || bus.o_alu_b !== 8'h03 ||
        bus.o_alu_op !== 6'h20) begin
      bad++;
      $display("FAIL add_idle: got busy=%b a=%h b=%h op=%h want 0/05/03/20",
               bus.o_busy, bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);
    end
  endtask

  task automatic test_sub();
    send_byte(8'h03);
    send_byte(8'h05);
    send_byte(8'hE2);
    total++;
    if (bus.o_alu_op !== 6'h22) begin
      bad++;
      $display("FAIL sub_op: got %h want 22", bus.o_alu_op);
    end
    cycle();
    total++;
    if (bus.o_tx_start !== 1'b1 || bus.o_tx_data !== 8'hFE) begin
      bad++;
      $display("FAIL sub_data: got start=%b data=%h want 1/FE", bus.o_tx_start, bus.o_tx_data);
    end
    cycle();
    pulse_tx_done();
  endtask

  task automatic test_sra_illegal();
    send_byte(8'h80);
    send_byte(8'h02);
    send_byte(8'h03);
    cycle();
    total++;
    if (bus.o_tx_start !== 1'b1 || bus.o_tx_data !== 8'hE0) begin
      bad++;
      $display("FAIL sra_data: got start=%b data=%h want 1/E0", bus.o_tx_start, bus.o_tx_data);
    end
    cycle();
    pulse_tx_done();
    send_byte(8'h80);
    send_byte(8'h02);
    send_byte(8'h3F);
    cycle();
    total++;
    if (bus.o_tx_start !== 1'b1 || bus.o_tx_data !== 8'h00 || bus.o_alu_op !== 6'h3F) begin
      bad++;
      $display("FAIL illegal_op: got start=%b data=%h op=%h want 1/00/3F",
               bus.o_tx_start, bus.o_tx_data, bus.o_alu_op);
    end
    cycle();
    pulse_tx_done();
  endtask

  task automatic test_drop();
    send_byte(8'h0A);
    send_byte(8'h05);
    send_byte(8'h20);
    cycle();
    cycle();
    // Now in WAIT_TX holding 0x0F.
    send_byte(8'h55);
    total++;
    if (bus.o_drop !== 1'b1 || bus.o_tx_data !== 8'h0F || bus.o_alu_a !== 8'h0A ||
        bus.o_busy !== 1'b1) begin
      bad++;
      $display("FAIL drop_wait_tx: got drop=%b data=%h a=%h busy=%b want 1/0F/0A/1",
               bus.o_drop, bus.o_tx_data, bus.o_alu_a, bus.o_busy);
    end
    cycle();
    total++;
    if (bus.o_drop !== 1'b0) begin
      bad++;
      $display("FAIL drop_pulse_len: got %b want 0", bus.o_drop);
    end
    pulse_tx_done();
    total++;
    if (bus.o_busy !== 1'b0 || bus.o_tx_data !== 8'h0F) begin
      bad++;
      $display("FAIL drop_release: got busy=%b data=%h want 0/0F", bus.o_busy, bus.o_tx_data);
    end
    send_byte(8'h44);
    total++;
    if (bus.o_alu_a !== 8'h44 || bus.o_busy !== 1'b0) begin
      bad++;
      $display("FAIL back_in_wait_a: got a=%h busy=%b want 44/0", bus.o_alu_a, bus.o_busy);
    end
    // tx_done in WAIT_B must not disturb the frame.
    pulse_tx_done();
    send_byte(8'h01);
    send_byte(8'h26);
    // Byte arriving in EXEC is dropped.
    send_byte(8'h99);
    total++;
    if (bus.o_drop !== 1'b1 || bus.o_tx_start !== 1'b1 || bus.o_tx_data !== 8'h45 ||
        bus.o_alu_a !== 8'h44 || bus.o_alu_b !== 8'h01 || bus.o_alu_op !== 6'h26) begin
      bad++;
      $display("FAIL drop_exec: got drop=%b start=%b data=%h a=%h b=%h op=%h want 1/1/45/44/01/26",
               bus.o_drop, bus.o_tx_start, bus.o_tx_data, bus.o_alu_a, bus.o_alu_b,
               bus.o_alu_op);
    end
    cycle();
    pulse_tx_done();
  endtask

  task automatic test_reset_mid();
    logic saw_start;
    saw_start = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_data} !== 30'h0 ||
        {bus.o_tx_start, bus.o_busy, bus.o_drop, bus.o_timeout} !== 4'b0) begin
      bad++;
      $display("FAIL mid_reset_async: got a=%h b=%h op=%h tx=%h flags=%b want all 0",
               bus.o_alu_a, bus.o_alu_b, bus.o_alu_op, bus.o_tx_data,
               {bus.o_tx_start, bus.o_busy, bus.o_drop, bus.o_timeout});
    end
    bus.i_rx_data = 8'h20;
    bus.i_rx_done = 1'b1;
    cycle();
    bus.i_rx_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (bus.o_tx_start === 1'b1) saw_start = 1'b1;
    end
    total++;
    if (saw_start !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_no_start: got start seen=%b want 0", saw_start);
    end
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h20);
    cycle();
    total++;
    if (bus.o_tx_start !== 1'b1 || bus.o_tx_data !== 8'h03) begin
      bad++;
      $display("FAIL mid_reset_next: got start=%b data=%h want 1/03",
               bus.o_tx_start, bus.o_tx_data);
    end
    cycle();
    pulse_tx_done();
  endtask

`ifdef UART_ALU_TIMEOUT_EN
  task automatic test_timeout();
    logic exp_tmo;
    send_byte(8'h01);
    for (int i = 1; i <= 16; i++) begin
      cycle();
      exp_tmo = (i == 16);
      total++;
      if (bus.o_timeout !== exp_tmo) begin
        bad++;
        $display("FAIL timeout_cycle%0d: got %b want %b", i, bus.o_timeout, exp_tmo);
      end
    end
    cycle();
    total++;
    if (bus.o_timeout !== 1'b0) begin
      bad++;
      $display("FAIL timeout_pulse_len: got %b want 0", bus.o_timeout);
    end
    send_byte(8'h07);
    total++;
    if (bus.o_alu_a !== 8'h07 || bus.o_alu_b !== 8'h02) begin
      bad++;
      $display("FAIL timeout_wait_a: got a=%h b=%h want 07/02", bus.o_alu_a, bus.o_alu_b);
    end
    // Byte in the expiry cycle wins.
    for (int i = 0; i < 15; i++) cycle();
    send_byte(8'h09);
    total++;
    if (bus.o_timeout !== 1'b0 || bus.o_alu_b !== 8'h09) begin
      bad++;
      $display("FAIL timeout_priority: got tmo=%b b=%h want 0/09", bus.o_timeout, bus.o_alu_b);
    end
    send_byte(8'h20);
    cycle();
    total++;
    if (bus.o_tx_start !== 1'b1 || bus.o_tx_data !== 8'h10) begin
      bad++;
      $display("FAIL timeout_frame: got start=%b data=%h want 1/10",
               bus.o_tx_start, bus.o_tx_data);
    end
    cycle();
    pulse_tx_done();
  endtask
`else
  task automatic test_timeout();
    logic saw_tmo;
    saw_tmo = 1'b0;
    send_byte(8'h01);
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (bus.o_timeout !== 1'b0) saw_tmo = 1'b1;
    end
    total++;
    if (saw_tmo !== 1'b0) begin
      bad++;
      $display("FAIL no_timeout: got timeout seen=%b want 0", saw_tmo);
    end
    send_byte(8'h02);
    send_byte(8'h20);
    cycle();
    total++;
    if (bus.o_tx_start !== 1'b1 || bus.o_tx_data !== 8'h03 || bus.o_alu_a !== 8'h01) begin
      bad++;
      $display("FAIL no_timeout_frame: got start=%b data=%h a=%h want 1/03/01",
               bus.o_tx_start, bus.o_tx_data, bus.o_alu_a);
    end
    cycle();
    pulse_tx_done();
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_sra_illegal();
    test_drop();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
